// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-ported unified memory between the instruction-fetch requester and the
// load/store requester of the 5-stage MiniRisc core. Data requests win by default; after
// STARVE_MAX consecutive data grants with a fetch waiting, fetch is forced. Each access
// runs IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE, and the owner is acked in DONE.
// A branch flush kills an in-flight fetch: it still runs to completion, but with no ack
// and no read-data update.
//
// Ports:
//   Clock, Reset_                 clock (rising edge), asynchronous active-low reset
//   IF_Req/IF_Addr/IF_Flush       fetch request, address, branch flush
//   IF_Ack/IF_RData/IF_Stall      fetch ack pulse, fetched word (held), stall
//   D_Req/D_Wen/D_Addr/D_WData    load/store request, store flag, address, store data
//   D_Ben                         store byte enables
//   D_Ack/D_RData/D_Stall         data ack pulse, load data (held), stall
//   Mem_Cen/Mem_Wen               memory chip/write enable (ISSUE cycle only)
//   Mem_Addr/Mem_WData/Mem_Ben    registered memory address, store data, byte enables
//   Mem_RData                     memory read data, valid MEM_LAT cycles after issue
//   Owner                         0 = fetch, 1 = data; owner of the last grant

module mem_port_arbiter #(
    parameter int unsigned ADDRW      = 8,
    parameter int unsigned DATAWIDTH  = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                 Clock,
    input  logic                 Reset_,
    input  logic                 IF_Req,
    input  logic [ADDRW-1:0]     IF_Addr,
    input  logic                 IF_Flush,
    output logic                 IF_Ack,
    output logic [DATAWIDTH-1:0] IF_RData,
    output logic                 IF_Stall,
    input  logic                 D_Req,
    input  logic                 D_Wen,
    input  logic [ADDRW-1:0]     D_Addr,
    input  logic [DATAWIDTH-1:0] D_WData,
    input  logic [3:0]           D_Ben,
    output logic                 D_Ack,
    output logic [DATAWIDTH-1:0] D_RData,
    output logic                 D_Stall,
    output logic                 Mem_Cen,
    output logic                 Mem_Wen,
    output logic [ADDRW-1:0]     Mem_Addr,
    output logic [DATAWIDTH-1:0] Mem_WData,
    output logic [3:0]           Mem_Ben,
    input  logic [DATAWIDTH-1:0] Mem_RData,
    output logic                 Owner
);

    // Counter width that still holds STARVE_MAX when it is 0.
    localparam int unsigned SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] StarveMax = SW'(STARVE_MAX);
    localparam logic [3:0]    CntInit   = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [3:0]             r_cnt;
    logic [SW-1:0]          r_starve;
    logic                   r_owner;
    logic                   r_wen;
    logic                   r_kill;
    logic [ADDRW-1:0]       r_mem_addr;
    logic [DATAWIDTH-1:0]   r_mem_wdata;
    logic [3:0]             r_mem_ben;
    logic [DATAWIDTH-1:0]   r_if_rdata;
    logic [DATAWIDTH-1:0]   r_d_rdata;

    logic w_if_valid;
    logic w_force_if;
    logic w_grant_if;
    logic w_grant_d;
    logic w_rdone;

    // Arbitration: a flushed fetch request is invisible to the arbiter.
    always_comb begin
        w_if_valid = IF_Req & ~IF_Flush;
        w_force_if = (STARVE_MAX != 0) && (r_starve == StarveMax) && w_if_valid;
        w_grant_if = (r_state == StIdle) && (w_force_if || (w_if_valid && !D_Req));
        w_grant_d  = (r_state == StIdle) && !w_grant_if && D_Req;
        w_rdone    = (r_state == StWait) && (r_cnt == 4'd0);
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (w_grant_if || w_grant_d) w_state_nxt = StIssue;
            StIssue: w_state_nxt = StWait;
            StWait:  if (r_cnt == 4'd0) w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_) begin
        if (!Reset_) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_starve    <= '0;
            r_owner     <= 1'b0;
            r_wen       <= 1'b0;
            r_kill      <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_ben   <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_grant_if || w_grant_d) begin
                r_owner     <= w_grant_d;
                r_mem_addr  <= w_grant_d ? D_Addr : IF_Addr;
                r_mem_wdata <= w_grant_d ? D_WData : '0;
                r_mem_ben   <= w_grant_d ? D_Ben : '0;
                r_wen       <= w_grant_d & D_Wen;
                // Only data grants that bypass a live fetch request count toward starvation.
                if (w_grant_if || !w_if_valid) begin
                    r_starve <= '0;
                end else if (r_starve != StarveMax) begin
                    r_starve <= r_starve + SW'(1);
                end
            end

            if (r_state == StIssue) begin
                r_cnt <= CntInit;
            end else if ((r_state == StWait) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (r_state == StIdle) begin
                r_kill <= 1'b0;
            end else if (!r_owner && IF_Flush) begin
                r_kill <= 1'b1;
            end

            // Read data is valid in the last WAIT cycle; a flush in that same cycle also kills.
            if (w_rdone) begin
                if (!r_owner && !r_kill && !IF_Flush) begin
                    r_if_rdata <= Mem_RData;
                end
                if (r_owner && !r_wen) begin
                    r_d_rdata <= Mem_RData;
                end
            end
        end
    end

    always_comb begin
        Mem_Cen   = (r_state == StIssue);
        Mem_Wen   = (r_state == StIssue) & r_wen;
        Mem_Addr  = r_mem_addr;
        Mem_WData = r_mem_wdata;
        Mem_Ben   = r_mem_ben;
        Owner     = r_owner;
        IF_RData  = r_if_rdata;
        D_RData   = r_d_rdata;
        IF_Ack    = (r_state == StDone) & ~r_owner & ~r_kill & ~IF_Flush;
        D_Ack     = (r_state == StDone) & r_owner;
        IF_Stall  = IF_Req & ~IF_Ack;
        D_Stall   = D_Req & ~D_Ack;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: behavioural memory with MEM_LAT read latency, expected
// acks queued in a scoreboard as requests are driven and compared when acks appear.

module tb_mem_port_arbiter;

    localparam int TB_LAT = 2;

    logic        Clock = 1'b0;
    logic        Reset_ = 1'b0;
    logic        IF_Req = 1'b0;
    logic [7:0]  IF_Addr = '0;
    logic        IF_Flush = 1'b0;
    logic        IF_Ack;
    logic [31:0] IF_RData;
    logic        IF_Stall;
    logic        D_Req = 1'b0;
    logic        D_Wen = 1'b0;
    logic [7:0]  D_Addr = '0;
    logic [31:0] D_WData = '0;
    logic [3:0]  D_Ben = '0;
    logic        D_Ack;
    logic [31:0] D_RData;
    logic        D_Stall;
    logic        Mem_Cen;
    logic        Mem_Wen;
    logic [7:0]  Mem_Addr;
    logic [31:0] Mem_WData;
    logic [3:0]  Mem_Ben;
    logic [31:0] Mem_RData;
    logic        Owner;

    mem_port_arbiter #(
        .ADDRW      (8),
        .DATAWIDTH  (32),
        .MEM_LAT    (TB_LAT),
        .STARVE_MAX (3)
    ) dut (
        .Clock     (Clock),
        .Reset_    (Reset_),
        .IF_Req    (IF_Req),
        .IF_Addr   (IF_Addr),
        .IF_Flush  (IF_Flush),
        .IF_Ack    (IF_Ack),
        .IF_RData  (IF_RData),
        .IF_Stall  (IF_Stall),
        .D_Req     (D_Req),
        .D_Wen     (D_Wen),
        .D_Addr    (D_Addr),
        .D_WData   (D_WData),
        .D_Ben     (D_Ben),
        .D_Ack     (D_Ack),
        .D_RData   (D_RData),
        .D_Stall   (D_Stall),
        .Mem_Cen   (Mem_Cen),
        .Mem_Wen   (Mem_Wen),
        .Mem_Addr  (Mem_Addr),
        .Mem_WData (Mem_WData),
        .Mem_Ben   (Mem_Ben),
        .Mem_RData (Mem_RData),
        .Owner     (Owner)
    );

    always #5 Clock = ~Clock;

    // Behavioural memory: read data appears exactly TB_LAT cycles after the issue cycle.
    logic [31:0] mem [256];
    logic [31:0] rd_pipe [TB_LAT];
    assign Mem_RData = rd_pipe[TB_LAT-1];

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] a;
        a = 8'(i);
        case (i)
            16:      return 32'hDEADBEEF;
            32:      return 32'hCAFEF00D;
            48:      return 32'hAABBCCDD;
            default: return {a, ~a, 8'h5A, a + 8'h33};
        endcase
    endfunction

    always @(posedge Clock) begin
        if (!Reset_) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (Mem_Cen && Mem_Wen) begin
            for (int b = 0; b < 4; b++) begin
                if (Mem_Ben[b]) mem[Mem_Addr][8*b +: 8] <= Mem_WData[8*b +: 8];
            end
        end
        rd_pipe[0] <= (Mem_Cen && !Mem_Wen) ? mem[Mem_Addr] : 32'hBAD0BAD0;
        for (int i = 1; i < TB_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    typedef struct {
        bit          is_data;
        logic [31:0] data;
        int          ack_cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] exp_if_last = '0;
    logic [31:0] exp_d_last = '0;

    task automatic next_cycle();
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    task automatic push_exp(input bit is_data, input logic [31:0] data, input int ack_cyc);
        exp_t e;
        e.is_data = is_data;
        e.data    = data;
        e.ack_cyc = ack_cyc;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        @(negedge Clock);
        n_checks++;
        if ({IF_Ack, D_Ack, IF_Stall, D_Stall, Mem_Cen, Mem_Wen, Owner} !== 7'b0 ||
            Mem_Addr !== 8'h0 || Mem_WData !== 32'h0 || Mem_Ben !== 4'h0 ||
            IF_RData !== 32'h0 || D_RData !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: acks=%b%b cen=%b wen=%b own=%b addr=%h wd=%h ben=%h ifr=%h dr=%h, required all 0",
                     IF_Ack, D_Ack, Mem_Cen, Mem_Wen, Owner, Mem_Addr, Mem_WData, Mem_Ben,
                     IF_RData, D_RData);
        end
        @(negedge Clock);
        Reset_ = 1'b1;
    endtask

    task automatic test_fetch();
        int c0;
        bit ack_seen;
        exp_t e;
        logic [31:0] got;
        next_cycle();
        c0 = cyc;
        IF_Req = 1'b1;
        IF_Addr = 8'h10;
        push_exp(1'b0, 32'hDEADBEEF, c0 + 4);
        exp_if_last = 32'hDEADBEEF;
        for (int k = 0; k < 8; k++) begin
            @(negedge Clock);
            ack_seen = IF_Ack;
            if (k <= 4) begin
                n_checks++;
                if (IF_Stall !== (k < 4)) begin
                    n_fail++;
                    $display("FAIL fetch_stall k=%0d: got %b, required %b", k, IF_Stall, k < 4);
                end
            end
            n_checks++;
            if (Mem_Cen !== (k == 1) || (k == 1 && (Mem_Addr !== 8'h10 || Mem_Wen !== 1'b0))) begin
                n_fail++;
                $display("FAIL fetch_issue k=%0d: cen=%b addr=%h wen=%b, required cen=%b addr=10 wen=0",
                         k, Mem_Cen, Mem_Addr, Mem_Wen, k == 1);
            end
            if (IF_Ack || D_Ack) begin
                n_checks++;
                got = D_Ack ? D_RData : IF_RData;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL fetch_ack: unexpected ack at cycle %0d, required none", cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.is_data !== D_Ack || IF_Ack === D_Ack || cyc !== e.ack_cyc || got !== e.data) begin
                        n_fail++;
                        $display("FAIL fetch_ack: data=%b cyc=%0d rdata=%h, required data=%b cyc=%0d rdata=%h",
                                 D_Ack, cyc, got, e.is_data, e.ack_cyc, e.data);
                    end
                end
            end
            next_cycle();
            if (ack_seen) IF_Req = 1'b0;
        end
        n_checks++;
        if (sb.size() != 0 || IF_RData !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL fetch_done: pending=%0d rdata=%h, required 0 and deadbeef", sb.size(), IF_RData);
            sb.delete();
        end
    endtask

    task automatic test_priority();
        int c0;
        bit if_ack, d_ack;
        exp_t e;
        logic [31:0] got;
        c0 = cyc;
        IF_Req = 1'b1;
        IF_Addr = 8'h14;
        D_Req = 1'b1;
        D_Wen = 1'b0;
        D_Addr = 8'h20;
        push_exp(1'b1, mem[8'h20], c0 + 4);
        push_exp(1'b0, mem[8'h14], c0 + 9);
        exp_d_last = mem[8'h20];
        exp_if_last = mem[8'h14];
        for (int k = 0; k < 12; k++) begin
            @(negedge Clock);
            if_ack = IF_Ack;
            d_ack = D_Ack;
            if (k == 1 || k == 6) begin
                n_checks++;
                if (Owner !== (k == 1) || Mem_Cen !== 1'b1) begin
                    n_fail++;
                    $display("FAIL prio_owner k=%0d: owner=%b cen=%b, required owner=%b cen=1",
                             k, Owner, Mem_Cen, k == 1);
                end
            end
            if (k == 3 || k == 4) begin
                n_checks++;
                if (IF_Stall !== 1'b1 || D_Stall !== (k == 3)) begin
                    n_fail++;
                    $display("FAIL prio_stall k=%0d: if=%b d=%b, required if=1 d=%b", k, IF_Stall,
                             D_Stall, k == 3);
                end
            end
            if (IF_Ack || D_Ack) begin
                n_checks++;
                got = D_Ack ? D_RData : IF_RData;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL prio_ack: unexpected ack at cycle %0d, required none", cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.is_data !== D_Ack || IF_Ack === D_Ack || cyc !== e.ack_cyc || got !== e.data) begin
                        n_fail++;
                        $display("FAIL prio_ack: data=%b cyc=%0d rdata=%h, required data=%b cyc=%0d rdata=%h",
                                 D_Ack, cyc, got, e.is_data, e.ack_cyc, e.data);
                    end
                end
            end
            next_cycle();
            if (if_ack) IF_Req = 1'b0;
            if (d_ack) D_Req = 1'b0;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL prio_timeout: %0d acks missing, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_starvation();
        int c0;
        int d_acks;
        bit if_ack, d_ack;
        exp_t e;
        logic [31:0] got;
        c0 = cyc;
        d_acks = 0;
        IF_Req = 1'b1;
        IF_Addr = 8'h18;
        D_Req = 1'b1;
        D_Wen = 1'b0;
        D_Addr = 8'h20;
        push_exp(1'b1, mem[8'h20], c0 + 4);
        push_exp(1'b1, mem[8'h20], c0 + 9);
        push_exp(1'b1, mem[8'h20], c0 + 14);
        push_exp(1'b0, mem[8'h18], c0 + 19);
        push_exp(1'b1, mem[8'h20], c0 + 24);
        exp_if_last = mem[8'h18];
        for (int k = 0; k < 28; k++) begin
            @(negedge Clock);
            if_ack = IF_Ack;
            d_ack = D_Ack;
            if (D_Ack) d_acks++;
            if (IF_Ack || D_Ack) begin
                n_checks++;
                got = D_Ack ? D_RData : IF_RData;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL starve_ack: unexpected ack at cycle %0d, required none", cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.is_data !== D_Ack || IF_Ack === D_Ack || cyc !== e.ack_cyc || got !== e.data) begin
                        n_fail++;
                        $display("FAIL starve_ack: data=%b cyc=%0d rdata=%h, required data=%b cyc=%0d rdata=%h",
                                 D_Ack, cyc, got, e.is_data, e.ack_cyc, e.data);
                    end
                end
            end
            next_cycle();
            if (if_ack) IF_Req = 1'b0;
            if (d_ack && d_acks == 4) D_Req = 1'b0;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL starve_timeout: %0d acks missing, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_store();
        int c0;
        bit d_ack;
        exp_t e;
        logic [31:0] got;
        c0 = cyc;
        D_Req = 1'b1;
        D_Wen = 1'b1;
        D_Addr = 8'h30;
        D_WData = 32'h12345678;
        D_Ben = 4'b0011;
        push_exp(1'b1, exp_d_last, c0 + 4);
        for (int k = 0; k < 12; k++) begin
            @(negedge Clock);
            d_ack = D_Ack;
            if (k == 1) begin
                n_checks++;
                if (Mem_Cen !== 1'b1 || Mem_Wen !== 1'b1 || Mem_Addr !== 8'h30 ||
                    Mem_WData !== 32'h12345678 || Mem_Ben !== 4'b0011) begin
                    n_fail++;
                    $display("FAIL store_issue: cen=%b wen=%b addr=%h wd=%h ben=%b, required 1 1 30 12345678 0011",
                             Mem_Cen, Mem_Wen, Mem_Addr, Mem_WData, Mem_Ben);
                end
            end
            if (IF_Ack || D_Ack) begin
                n_checks++;
                got = D_Ack ? D_RData : IF_RData;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL store_ack: unexpected ack at cycle %0d, required none", cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.is_data !== D_Ack || IF_Ack === D_Ack || cyc !== e.ack_cyc || got !== e.data) begin
                        n_fail++;
                        $display("FAIL store_ack: data=%b cyc=%0d rdata=%h, required data=%b cyc=%0d rdata=%h",
                                 D_Ack, cyc, got, e.is_data, e.ack_cyc, e.data);
                    end
                end
            end
            next_cycle();
            // Read back the stored word: only the two low bytes were written.
            if (d_ack && k == 4) begin
                D_Wen = 1'b0;
                push_exp(1'b1, 32'hAABB5678, c0 + 9);
                exp_d_last = 32'hAABB5678;
            end else if (d_ack) begin
                D_Req = 1'b0;
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL store_timeout: %0d acks missing, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_flush();
        int c0;
        bit d_ack;
        exp_t e;
        logic [31:0] got;
        c0 = cyc;
        IF_Req = 1'b1;
        IF_Addr = 8'h1C;
        for (int k = 0; k < 11; k++) begin
            @(negedge Clock);
            d_ack = D_Ack;
            n_checks++;
            if (IF_Ack !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_noack k=%0d: if_ack=%b, required 0", k, IF_Ack);
            end
            if (k == 6) begin
                n_checks++;
                if (Mem_Cen !== 1'b1 || Owner !== 1'b1) begin
                    n_fail++;
                    $display("FAIL flush_sched: cen=%b owner=%b, required 1 1", Mem_Cen, Owner);
                end
            end
            if (D_Ack) begin
                n_checks++;
                got = D_RData;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL flush_ack: unexpected ack at cycle %0d, required none", cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.is_data !== 1'b1 || cyc !== e.ack_cyc || got !== e.data) begin
                        n_fail++;
                        $display("FAIL flush_ack: cyc=%0d rdata=%h, required data=%b cyc=%0d rdata=%h",
                                 cyc, got, e.is_data, e.ack_cyc, e.data);
                    end
                end
            end
            next_cycle();
            if (k == 1) IF_Flush = 1'b1;
            if (k == 2) begin
                IF_Flush = 1'b0;
                IF_Req = 1'b0;
                D_Req = 1'b1;
                D_Addr = 8'h24;
                push_exp(1'b1, mem[8'h24], c0 + 9);
                exp_d_last = mem[8'h24];
            end
            if (d_ack) D_Req = 1'b0;
        end
        n_checks++;
        if (sb.size() != 0 || IF_RData !== exp_if_last) begin
            n_fail++;
            $display("FAIL flush_rdata: pending=%0d if_rdata=%h, required 0 and %h", sb.size(),
                     IF_RData, exp_if_last);
            sb.delete();
        end
        // A fetch request presented together with a flush is never granted.
        IF_Req = 1'b1;
        IF_Flush = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clock);
            n_checks++;
            if (Mem_Cen !== 1'b0 || IF_Ack !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_idle k=%0d: cen=%b ack=%b, required 0 0", k, Mem_Cen, IF_Ack);
            end
            next_cycle();
        end
        IF_Req = 1'b0;
        IF_Flush = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        int c0;
        bit d_ack;
        exp_t e;
        logic [31:0] got;
        IF_Req = 1'b1;
        IF_Addr = 8'h10;
        repeat (2) next_cycle();
        @(negedge Clock);
        #2;
        Reset_ = 1'b0;
        IF_Req = 1'b0;
        #1;
        n_checks++;
        if ({IF_Ack, D_Ack, IF_Stall, D_Stall, Mem_Cen, Mem_Wen, Owner} !== 7'b0 ||
            Mem_Addr !== 8'h0 || Mem_WData !== 32'h0 || Mem_Ben !== 4'h0 ||
            IF_RData !== 32'h0 || D_RData !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_async: acks=%b%b cen=%b wen=%b own=%b addr=%h wd=%h ben=%h ifr=%h dr=%h, required all 0",
                     IF_Ack, D_Ack, Mem_Cen, Mem_Wen, Owner, Mem_Addr, Mem_WData, Mem_Ben,
                     IF_RData, D_RData);
        end
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset_ = 1'b1;
        next_cycle();
        c0 = cyc;
        D_Req = 1'b1;
        D_Wen = 1'b0;
        D_Addr = 8'h20;
        push_exp(1'b1, mem[8'h20], c0 + 4);
        for (int k = 0; k < 8; k++) begin
            @(negedge Clock);
            d_ack = D_Ack;
            if (IF_Ack || D_Ack) begin
                n_checks++;
                got = D_Ack ? D_RData : IF_RData;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rstmid_ack: unexpected ack at cycle %0d, required none", cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.is_data !== D_Ack || IF_Ack === D_Ack || cyc !== e.ack_cyc || got !== e.data) begin
                        n_fail++;
                        $display("FAIL rstmid_ack: data=%b cyc=%0d rdata=%h, required data=%b cyc=%0d rdata=%h",
                                 D_Ack, cyc, got, e.is_data, e.ack_cyc, e.data);
                    end
                end
            end
            next_cycle();
            if (d_ack) D_Req = 1'b0;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_timeout: %0d acks missing, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_starvation();
        test_store();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch requester and the load/store (MEM stage) requester of the 5-stage MiniRisc core.
- Arbitrates with fixed data priority plus an anti-starvation counter for fetch.
- Sequences each access over a fixed memory latency and returns per-requester stall signals to the pipeline.
- A branch flush cancels the acknowledge of an in-flight fetch.

Parameters:
- ADDRW, 8, address width of both requesters and the memory port.
- DATAWIDTH, 32, data width.
- MEM_LAT, 2, memory read latency in cycles from the issue cycle to valid Mem_RData; legal range 1..15.
- STARVE_MAX, 3, consecutive data grants allowed while IF_Req is pending before fetch is forced; 0 = strict data priority.

Ports:
- Clock  in  1  core clock, rising edge.
- Reset_  in  1  asynchronous active-low reset.
- IF_Req  in  1  fetch request; held until IF_Ack or flush.
- IF_Addr  in  ADDRW  fetch address; stable while IF_Req.
- IF_Flush  in  1  branch taken in ID; kills the pending or in-flight fetch.
- IF_Ack  out  1  one-cycle pulse; IF_RData valid.
- IF_RData  out  DATAWIDTH  fetched word; held until the next IF_Ack.
- IF_Stall  out  1  IF_Req & ~IF_Ack.
- D_Req  in  1  load/store request; held until D_Ack.
- D_Wen  in  1  1 = store, 0 = load.
- D_Addr  in  ADDRW  data address.
- D_WData  in  DATAWIDTH  store data.
- D_Ben  in  4  byte enables for the store.
- D_Ack  out  1  one-cycle pulse.
- D_RData  out  DATAWIDTH  load data; held until the next load D_Ack.
- D_Stall  out  1  D_Req & ~D_Ack.
- Mem_Cen  out  1  memory chip enable; high for exactly the issue cycle.
- Mem_Wen  out  1  memory write enable; valid with Mem_Cen.
- Mem_Addr  out  ADDRW  registered address.
- Mem_WData  out  DATAWIDTH  registered store data.
- Mem_Ben  out  4  registered byte enables.
- Mem_RData  in  DATAWIDTH  memory read data.
- Owner  out  1  0 = fetch, 1 = data; value of the last grant.

Behaviour:
- Reset: state IDLE. All outputs, Mem_* registers, RData registers and counters are 0. Reset asserted mid-access abandons the access with no Ack.
- FSM states:
  - IDLE: arbitrate every cycle.
  - ISSUE: Mem_Cen=1 for one cycle; Mem_Wen = D_Wen latched at grant for a data grant, 0 for a fetch grant.
  - WAIT: down-counter cnt runs from MEM_LAT-1 to 0.
  - DONE: Ack pulse cycle.
- Transitions: IDLE -> ISSUE on grant. ISSUE -> WAIT. WAIT -> DONE when cnt==0. DONE -> IDLE.
- MEM_LAT=1: WAIT lasts one cycle with cnt=0.
- Arbitration in IDLE:
  - IF_Req considered only if IF_Flush=0.
  - Fetch wins if (STARVE_MAX!=0 and starve==STARVE_MAX and IF_Req) or (IF_Req and !D_Req). Otherwise data wins if D_Req.
  - On grant, latch Addr, WData, Ben and Wen into the Mem_* registers and set Owner.
- Starve counter:
  - Increments, saturating at STARVE_MAX, on a data grant while a valid IF_Req is present.
  - Clears on a fetch grant, or on any grant when no valid IF_Req is present.
- Latency: a grant sampled at edge E0 gives ISSUE in cycle 1 and DONE (Ack) in cycle MEM_LAT+2. Back-to-back throughput is one access per MEM_LAT+3 cycles.
- DONE:
  - Loads and fetches capture Mem_RData at the WAIT->DONE edge into the owner's RData register.
  - Stores leave D_RData unchanged.
  - The owner's Ack is high for the DONE cycle only.
- Flush:
  - IF_Flush high in any cycle while fetch owns ISSUE, WAIT or DONE sets a kill flag. The access runs to completion, IF_Ack is suppressed and IF_RData is not updated.
  - IF_Flush never affects a data access. The kill flag clears in IDLE.
- Protocol: a requester may drop Req only after its Ack or after a flush. Dropping Req mid-access does not abort the access.
- Simultaneous requests: both IF_Req and D_Req in IDLE follow the arbitration rule. The loser sees Stall held with no loss.

Test Plan:
- MEM_LAT=2; IF_Req alone with IF_Addr=0x10 and memory word 0xDEADBEEF -> Mem_Cen in cycle 1 with Mem_Addr=0x10, IF_Ack in cycle 4, IF_RData=0xDEADBEEF, IF_Stall high cycles 0-3.
- IF_Req and D_Req both high, D load from 0x20 -> data granted first (Owner=1, D_Ack cycle 4), then fetch granted at cycle 5 with IF_Ack in cycle 9.
- STARVE_MAX=3; D_Req held continuously with IF_Req -> exactly 3 data Acks, then one IF_Ack, then starve=0 and data resumes.
- Store D_Wen=1, D_Addr=0x30, D_WData=0x12345678, D_Ben=4'b0011 -> Mem_Wen=1 with matching Mem_Ben and Mem_WData in the ISSUE cycle, D_Ack after the same latency, D_RData unchanged.
- Fetch in WAIT, IF_Flush pulsed for one cycle -> no IF_Ack, IF_RData unchanged, FSM returns to IDLE on schedule; IF_Req with IF_Flush in IDLE -> no grant.
- Reset_ driven low during WAIT -> all outputs 0 immediately and asynchronously; after release, a new request completes normally with no stale Ack.
